// File: rtl/select_step_pkg.sv
// rtl/select_step_pkg.sv - opcode constants shared by the select/step datapath
//
// Holds the 2-bit opcode encoding used on the select input:
//   OP_ADD  (00) result = number + STEP
//   OP_PASS (01) result = number
//   OP_SUB  (10) result = number - STEP
//   OP_HOLD (11) result = current result register
package select_step_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_PASS = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

endpackage

// File: rtl/select_step_alu.sv
// rtl/select_step_alu.sv - combinational add/pass/sub/hold datapath with wrap or clamp
//
// Optional feature: define SELECT_STEP_SATURATE_EN to clamp on overflow/underflow;
// otherwise arithmetic wraps modulo 2^WIDTH.
//
// Ports:
//   number      in  WIDTH  operand
//   select      in  2      opcode (see select_step_pkg)
//   held        in  WIDTH  current result register, used by OP_HOLD
//   next_result out WIDTH  value to load into the result register
//   next_flag   out 1      operation wrapped (or clamped)
module select_step_alu
  import select_step_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] number,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] held,
  output logic [WIDTH-1:0] next_result,
  output logic             next_flag
);

  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  // One extra bit so the carry out of the add is visible.
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign sum    = {1'b0, number} + {1'b0, STEP_N};
  assign diff   = number - STEP_N;
  assign borrow = (number < STEP_N);

  always_comb begin
    next_result = held;
    next_flag   = 1'b0;
    case (select)
      OP_ADD: begin
        next_flag = sum[WIDTH];
`ifdef SELECT_STEP_SATURATE_EN
        next_result = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        next_result = sum[WIDTH-1:0];
`endif
      end
      OP_PASS: begin
        next_result = number;
      end
      OP_SUB: begin
        next_flag = borrow;
`ifdef SELECT_STEP_SATURATE_EN
        next_result = borrow ? {WIDTH{1'b0}} : diff;
`else
        next_result = diff;
`endif
      end
      default: begin
        // OP_HOLD: re-issue the current result; number is ignored.
        next_result = held;
      end
    endcase
  end

endmodule

// File: rtl/select_step_reg.sv
// rtl/select_step_reg.sv - one-entry valid/ready stage around the select/step ALU
//
// Optional feature: SELECT_STEP_SATURATE_EN (passed through to select_step_alu).
//
// Ports:
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   number    in  WIDTH  operand
//   select    in  2      opcode
//   in_valid  in  1      number/select valid
//   in_ready  out 1      stage can accept an operation
//   result    out WIDTH  registered result
//   out_valid out 1      result valid
//   out_ready in  1      consumer accepts result
//   flag      out 1      registered wrap/clamp indication of the last operation
module select_step_reg
  import select_step_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] number,
  input  logic [1:0]       select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag
);

  logic [WIDTH-1:0] alu_result;
  logic             alu_flag;
  logic             accept;

  select_step_alu #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_alu (
    .number      (number),
    .select      (select),
    .held        (result),
    .next_result (alu_result),
    .next_flag   (alu_flag)
  );

  // Single slot: free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flag      <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      result    <= alu_result;
      flag      <= alu_flag;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      // Drained with nothing new: result and flag keep their values.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_select_step_reg.sv
// tb/tb_select_step_reg.sv - directed self-checking bench for select_step_reg
module tb_select_step_reg;

  logic       clk;
  logic       rst_n;
  logic [7:0] number;
  logic [1:0] select;
  logic       in_valid;
  logic       out_ready;
  logic       in_ready;
  logic [7:0] result;
  logic       out_valid;
  logic       flag;
  logic       in_ready4;
  logic [7:0] result4;
  logic       out_valid4;
  logic       flag4;

  int checks   = 0;
  int failures = 0;

  select_step_reg #(.WIDTH(8), .STEP(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .number    (number),
    .select    (select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flag      (flag)
  );

  select_step_reg #(.WIDTH(8), .STEP(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .number    (number),
    .select    (select),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .result    (result4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .flag      (flag4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for a single edge with out_ready=1, then sample.
  task automatic issue(input logic [7:0] n, input logic [1:0] s);
    number    = n;
    select    = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    number    = 8'h00;
    select    = 2'b00;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #12;
    checks++;
    if ({result, flag, out_valid} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got result=%h flag=%b valid=%b expected 00 0 0", result, flag, out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_add;
    issue(8'h41, 2'b00);
    checks++;
    if ({result, flag, out_valid} !== {8'h42, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL add_41: got result=%h flag=%b valid=%b expected 42 0 1", result, flag, out_valid);
    end
    issue(8'hFF, 2'b00);
    checks++;
`ifdef SELECT_STEP_SATURATE_EN
    if ({result, flag} !== {8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL add_ff: got result=%h flag=%b expected ff 1", result, flag);
    end
`else
    if ({result, flag} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL add_ff: got result=%h flag=%b expected 00 1", result, flag);
    end
`endif
  endtask

  task automatic test_sub;
    issue(8'h00, 2'b10);
    checks++;
`ifdef SELECT_STEP_SATURATE_EN
    if ({result, flag} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL sub_00: got result=%h flag=%b expected 00 1", result, flag);
    end
`else
    if ({result, flag} !== {8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL sub_00: got result=%h flag=%b expected ff 1", result, flag);
    end
`endif
    issue(8'h05, 2'b10);
    checks++;
    if ({result, flag, out_valid} !== {8'h04, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL sub_05: got result=%h flag=%b valid=%b expected 04 0 1", result, flag, out_valid);
    end
  endtask

  task automatic test_pass_hold;
    issue(8'h5A, 2'b01);
    checks++;
    if ({result, flag} !== {8'h5A, 1'b0}) begin
      failures++;
      $display("FAIL pass_5a: got result=%h flag=%b expected 5a 0", result, flag);
    end
    issue(8'h00, 2'b11);
    checks++;
    if ({result, flag, out_valid} !== {8'h5A, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL hold_5a: got result=%h flag=%b valid=%b expected 5a 0 1", result, flag, out_valid);
    end
    // Hold after a flagged add: value kept, flag cleared.
    issue(8'hFF, 2'b00);
    issue(8'h33, 2'b11);
    checks++;
`ifdef SELECT_STEP_SATURATE_EN
    if ({result, flag} !== {8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL hold_after_flag: got result=%h flag=%b expected ff 0", result, flag);
    end
`else
    if ({result, flag} !== {8'h00, 1'b0}) begin
      failures++;
      $display("FAIL hold_after_flag: got result=%h flag=%b expected 00 0", result, flag);
    end
`endif
  endtask

  task automatic test_step4;
    issue(8'h10, 2'b10);
    checks++;
    if ({result4, flag4} !== {8'h0C, 1'b0}) begin
      failures++;
      $display("FAIL step4_sub: got result=%h flag=%b expected 0c 0", result4, flag4);
    end
    checks++;
    if (result !== 8'h0F) begin
      failures++;
      $display("FAIL step1_sub: got result=%h expected 0f", result);
    end
    issue(8'h02, 2'b10);
    checks++;
`ifdef SELECT_STEP_SATURATE_EN
    if ({result4, flag4} !== {8'h00, 1'b1}) begin
      failures++;
      $display("FAIL step4_under: got result=%h flag=%b expected 00 1", result4, flag4);
    end
`else
    if ({result4, flag4} !== {8'hFE, 1'b1}) begin
      failures++;
      $display("FAIL step4_under: got result=%h flag=%b expected fe 1", result4, flag4);
    end
`endif
  endtask

  task automatic test_backpressure;
    // Drain the stage first.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    number    = 8'h0F;
    select    = 2'b00;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({result, out_valid, in_ready} !== {8'h10, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL bp_load: got result=%h valid=%b in_ready=%b expected 10 1 0", result, out_valid, in_ready);
    end
    number = 8'h20;
    select = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({result, out_valid, in_ready} !== {8'h10, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold%0d: got result=%h valid=%b in_ready=%b expected 10 1 0", i, result, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({result, out_valid} !== {8'h20, 1'b1}) begin
      failures++;
      $display("FAIL bp_accept: got result=%h valid=%b expected 20 1", result, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({result, flag, out_valid} !== {8'h20, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL drain_only: got result=%h flag=%b valid=%b expected 20 0 0", result, flag, out_valid);
    end
  endtask

  task automatic test_async_reset;
    number    = 8'hFF;
    select    = 2'b00;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({result, flag, out_valid} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset: got result=%h flag=%b valid=%b expected 00 0 0", result, flag, out_valid);
    end
    number   = 8'h30;
    select   = 2'b01;
    in_valid = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({result, out_valid, in_ready} !== {8'h00, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL after_release: got result=%h valid=%b in_ready=%b expected 00 0 1", result, out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({result, flag, out_valid} !== {8'h30, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL first_accept: got result=%h flag=%b valid=%b expected 30 0 1", result, flag, out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_pass_hold;
    test_step4;
    test_backpressure;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/select_step_reg.md
SELECT_STEP_REG -- requirements
Module: select_step_reg

Interface
REQ-001 Parameter WIDTH, default 8, data width of number and result (≥2).
REQ-002 Parameter STEP, default 1, increment/decrement magnitude (1 ≤ STEP < 2^WIDTH).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 number  input  WIDTH  operand.
REQ-006 select  input  2  opcode: 00 add STEP, 01 pass, 10 subtract STEP, 11 hold last result.
REQ-007 in_valid  input  1  number/select valid.
REQ-008 in_ready  output  1  block can accept an operation.
REQ-009 result  output  WIDTH  registered result.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 flag  output  1  registered; result of the current operation wrapped or saturated.

Function
REQ-013 Every opcode is decoded; no opcode leaves result unassigned, and no latch is inferred.
REQ-014 Input accepted on a clk edge when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-015 in_ready = !out_valid || out_ready (combinational; one-entry pipeline, full throughput).
REQ-016 Latency: accepted operation appears on result/out_valid the cycle after acceptance.
REQ-017 While out_valid && !out_ready, result, flag and out_valid are held stable.
REQ-018 Acceptance with simultaneous consumption loads the new result; out_valid stays 1.
REQ-019 Consumption without acceptance clears out_valid; result and flag retain their values.
REQ-020 00: number + STEP, width WIDTH+1 internally; flag=1 when sum ≥ 2^WIDTH.
REQ-021 10: number − STEP; flag=1 when number < STEP.
REQ-022 01: result=number, flag=0.
REQ-023 11: result=current result register (number ignored), flag=0; valid handshake still applies.
REQ-024 in_valid with in_ready=0 has no effect; the producer holds its inputs.

Reset
REQ-025 rst_n low: result=0, out_valid=0, flag=0 immediately, regardless of clk.
REQ-026 Reset mid-transfer discards the pending result; in_ready=1 from the first cycle after release.
REQ-027 Deassertion is sampled synchronously; the first acceptance occurs at the earliest on the first rising edge after release.

Configuration
REQ-028 Macro SELECT_STEP_SATURATE_EN defined: overflow clamps to 2^WIDTH−1, underflow clamps to 0; flag marks the clamp.
REQ-029 Macro undefined: arithmetic wraps modulo 2^WIDTH; flag marks the wrap.

Structure
REQ-030 Package select_step_pkg holds the opcode constants OP_ADD, OP_PASS, OP_SUB and OP_HOLD.
REQ-031 Sub-module select_step_alu: combinational; inputs number, select, held result; outputs next result and flag; contains all arithmetic and the saturate/wrap choice.
REQ-032 The top level contains only the handshake logic and the registers.

Verification
REQ-033 WIDTH=8, STEP=1: number=0x41, select=00, out_ready=1 -> next cycle result=0x42, flag=0, out_valid=1.
REQ-034 number=0xFF, select=00 -> wrap build: result=0x00, flag=1. SELECT_STEP_SATURATE_EN build: result=0xFF, flag=1.
REQ-035 number=0x00, select=10 -> wrap build: result=0xFF, flag=1. Saturate build: result=0x00, flag=1.
REQ-036 Backpressure: out_ready=0 for 3 cycles after result 0x10 -> result holds 0x10, in_ready=0. Release -> the next input is accepted on the same edge.
REQ-037 Pass 0x5A then hold (select=11, number=0x00) -> results 0x5A, 0x5A. STEP=4, number=0x10, select=10 -> result=0x0C.
REQ-038 rst_n asserted while out_valid=1 and out_ready=0 -> result=0, out_valid=0, flag=0 asynchronously.
